// File: rtl/cursor_src.sv
// Hardware cursor overlay: reads the 32x32 2-bit cursor bitmap and paints it over the RGB stream.
// Latency: 3 clocks from x/y/si_rgb to so_rgb; ram_addr leads ram_data by 1 clock.
// Backpressure: none, the pipeline advances every clock.
module cursor_src #(
  parameter int CD = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          frame_start,
  input  logic [CD-1:0] si_rgb,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [31:0]   wr_data,
  output logic [9:0]    ram_addr,
  input  logic [1:0]    ram_data,
  output logic [CD-1:0] so_rgb
);

  localparam logic [CD-1:0] PAL3_RST = ~({CD{1'b1}} >> (CD / 3));

  logic [10:0]   x0_p, y0_p, x0_a, y0_a;
  logic          en_p, bl_p, en_a, bl_a;
  logic [10:0]   x0_nxt, y0_nxt;
  logic          en_nxt, bl_nxt;
  logic [5:0]    blink_cnt;
  logic [CD-1:0] pal1, pal2, pal3;

  logic [11:0]   xr, yr;
  logic          hit, visible;
  logic          hit1, hit2;
  logic [CD-1:0] rgb1, rgb2;
  logic [CD-1:0] ovl_rgb;

  logic          unused_wr;
  assign unused_wr = ^wr_data[31:11];

  // Pending values including a write in this cycle, so a coincident frame_start sees it.
  always_comb begin
    x0_nxt = x0_p;
    y0_nxt = y0_p;
    en_nxt = en_p;
    bl_nxt = bl_p;
    if (wr_en) begin
      case (wr_addr)
        3'd0: x0_nxt = wr_data[10:0];
        3'd1: y0_nxt = wr_data[10:0];
        3'd2: begin
          en_nxt = wr_data[0];
          bl_nxt = wr_data[1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x0_p      <= '0;
      y0_p      <= '0;
      en_p      <= 1'b0;
      bl_p      <= 1'b0;
      x0_a      <= '0;
      y0_a      <= '0;
      en_a      <= 1'b0;
      bl_a      <= 1'b0;
      blink_cnt <= '0;
      pal1      <= '1;
      pal2      <= '0;
      pal3      <= PAL3_RST;
    end else begin
      x0_p <= x0_nxt;
      y0_p <= y0_nxt;
      en_p <= en_nxt;
      bl_p <= bl_nxt;
      if (frame_start) begin
        x0_a      <= x0_nxt;
        y0_a      <= y0_nxt;
        en_a      <= en_nxt;
        bl_a      <= bl_nxt;
        blink_cnt <= blink_cnt + 6'd1;
      end
      if (wr_en) begin
        case (wr_addr)
          3'd3:    pal1 <= wr_data[CD-1:0];
          3'd4:    pal2 <= wr_data[CD-1:0];
          3'd5:    pal3 <= wr_data[CD-1:0];
          default: ;
        endcase
      end
    end
  end

  // 12-bit difference: x below x0 goes large and misses, x0 near 2047 never wraps to column 0.
  assign xr      = {1'b0, x} - {1'b0, x0_a};
  assign yr      = {1'b0, y} - {1'b0, y0_a};
  assign hit     = (xr[11:5] == 7'd0) && (yr[11:5] == 7'd0);
  assign visible = en_a && (!bl_a || !blink_cnt[5]);

  always_comb begin
    ovl_rgb = rgb2;
    if (hit2) begin
      case (ram_data)
        2'b01:   ovl_rgb = pal1;
        2'b10:   ovl_rgb = pal2;
        2'b11:   ovl_rgb = pal3;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr <= '0;
      hit1     <= 1'b0;
      rgb1     <= '0;
      hit2     <= 1'b0;
      rgb2     <= '0;
      so_rgb   <= '0;
    end else begin
      ram_addr <= {yr[4:0], xr[4:0]};
      hit1     <= hit && visible;
      rgb1     <= si_rgb;
      hit2     <= hit1;
      rgb2     <= rgb1;
      so_rgb   <= ovl_rgb;
    end
  end

endmodule

// File: tb/tb_cursor_src.sv
// Randomized bench for cursor_src with a frame-level reference model and literal spot checks.
module tb_cursor_src;
  localparam int CD = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   x, y;
  logic          frame_start;
  logic [CD-1:0] si_rgb;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [9:0]    ram_addr;
  logic [1:0]    ram_data;
  logic [CD-1:0] so_rgb;

  logic [1:0]    mem [1024];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  cursor_src #(.CD(CD)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
    .si_rgb(si_rgb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_addr(ram_addr), .ram_data(ram_data), .so_rgb(so_rgb)
  );

  // Cursor bitmap RAM with one clock of read latency.
  always @(posedge clk) ram_data <= mem[ram_addr];

  // Reference model: cursor is a 32x32 box at the latched origin, drawn when enabled and in the "on" half of the blink period.
  int            m_x0p, m_y0p, m_x0a, m_y0a, m_cnt;
  bit            m_enp, m_blp, m_ena, m_bla;
  logic [CD-1:0] m_pal [4];
  bit            s1_hit, s2_hit;
  logic [CD-1:0] s1_rgb, s2_rgb;
  int            s1_addr;
  logic [1:0]    s2_code;
  logic [CD-1:0] exp_so;
  logic [9:0]    exp_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  xi, yi;
    bit  vis, inbox;
    if (reset) begin
      m_x0p = 0; m_y0p = 0; m_x0a = 0; m_y0a = 0; m_cnt = 0;
      m_enp = 0; m_blp = 0; m_ena = 0; m_bla = 0;
      m_pal[0] = '0; m_pal[1] = 12'hFFF; m_pal[2] = 12'h000; m_pal[3] = 12'hF00;
      s1_hit = 0; s1_rgb = '0; s1_addr = 0;
      s2_hit = 0; s2_rgb = '0; s2_code = 2'b00;
      exp_so = '0; exp_addr = '0;
    end else begin
      exp_so  = (s2_hit && s2_code != 2'b00) ? m_pal[s2_code] : s2_rgb;
      s2_hit  = s1_hit;
      s2_rgb  = s1_rgb;
      s2_code = mem[s1_addr];
      xi = int'(x);
      yi = int'(y);
      vis   = m_ena && (!m_bla || (m_cnt % 64) < 32);
      inbox = xi >= m_x0a && xi < m_x0a + 32 && yi >= m_y0a && yi < m_y0a + 32;
      s1_hit  = inbox && vis;
      s1_rgb  = si_rgb;
      s1_addr = ((yi - m_y0a) & 31) * 32 + ((xi - m_x0a) & 31);
      exp_addr = s1_addr[9:0];
      if (wr_en) begin
        case (wr_addr)
          3'd0: m_x0p = int'(wr_data[10:0]);
          3'd1: m_y0p = int'(wr_data[10:0]);
          3'd2: begin m_enp = wr_data[0]; m_blp = wr_data[1]; end
          3'd3: m_pal[1] = wr_data[CD-1:0];
          3'd4: m_pal[2] = wr_data[CD-1:0];
          3'd5: m_pal[3] = wr_data[CD-1:0];
          default: ;
        endcase
      end
      if (frame_start) begin
        m_x0a = m_x0p; m_y0a = m_y0p; m_ena = m_enp; m_bla = m_blp;
        m_cnt++;
      end
    end
  endtask

  // One clock: advance the model, clock the DUT, compare every output.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("so_rgb", so_rgb, exp_so);
    chk("ram_addr", ram_addr, exp_addr);
    wr_en = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pix(input int px, input int py, input logic [CD-1:0] c);
    x = px[10:0];
    y = py[10:0];
    si_rgb = c;
    tick();
  endtask

  task automatic pixr(input int px, input int py);
    pix(px, py, CD'($urandom));
  endtask

  task automatic idle();
    pixr(2047, 2047);
  endtask

  task automatic wreg(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    idle();
  endtask

  task automatic fs();
    frame_start = 1'b1;
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(); idle();
    reset = 1'b0;
  endtask

  task automatic scan(input int xa, input int xb, input int ya, input int yb);
    for (int yy = ya; yy <= yb; yy++)
      for (int xx = xa; xx <= xb; xx++)
        pixr(xx, yy);
  endtask

  // Literal expectation for a single pixel, 3 clocks after it is presented.
  task automatic probe(input string name, input int px, input int py,
                       input logic [CD-1:0] c, input logic [CD-1:0] want);
    pix(px, py, c);
    idle();
    idle();
    chk(name, so_rgb, want);
  endtask

  task automatic fill_mem(input logic [1:0] v);
    for (int i = 0; i < 1024; i++) mem[i] = v;
  endtask

  initial begin
    logic [CD-1:0] c;
    int ox, oy, xa, xb;
    fill_mem(2'b01);
    reset = 1'b1; x = '0; y = '0; frame_start = 1'b0; si_rgb = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    idle(); idle();
    chk("rst_so_rgb", so_rgb, 12'h000);
    chk("rst_ram_addr", ram_addr, 10'd0);
    reset = 1'b0;

    // Basic overlay at (100,50), all pixels code 01.
    wreg(3'd0, 32'd100); wreg(3'd1, 32'd50); wreg(3'd2, 32'd1);
    c = CD'($urandom);
    probe("before_fs_hidden", 100, 50, c, c);
    fs();
    probe("corner_tl", 100, 50, 12'h321, 12'hFFF);
    probe("corner_br", 131, 81, 12'h321, 12'hFFF);
    probe("x_plus_32", 132, 50, 12'h654, 12'h654);
    probe("x_minus_1", 99, 50, 12'h789, 12'h789);
    probe("y_plus_32", 100, 82, 12'hABC, 12'hABC);
    scan(96, 135, 48, 83);

    // Transparent and palette3 codes on row 0.
    mem[3] = 2'b00; mem[4] = 2'b11;
    pix(103, 50, 12'h123);
    pix(104, 50, 12'h456);
    chk("ram_addr_104", ram_addr, 10'd4);
    idle();
    chk("transparent_103", so_rgb, 12'h123);
    idle();
    chk("pal3_104", so_rgb, 12'hF00);

    // Random bitmap, palettes, positions and stray register traffic.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 1024; i++) mem[i] = 2'($urandom);
      wreg(3'd3, $urandom); wreg(3'd4, $urandom); wreg(3'd5, $urandom);
      ox = $urandom_range(2047); oy = $urandom_range(200);
      wreg(3'd0, ox); wreg(3'd1, oy); wreg(3'd2, ($urandom_range(3) != 0) ? 32'd1 : 32'd0);
      fs();
      xa = (ox < 8) ? 0 : ox - 8;
      xb = (ox + 40 > 2047) ? 2047 : ox + 40;
      for (int r = 0; r < 5; r++) begin
        for (int xx = xa; xx <= xb; xx++) begin
          if ($urandom_range(15) == 0) begin
            wr_en = 1'b1; wr_addr = 3'($urandom); wr_data = $urandom;
          end
          if ($urandom_range(63) == 0) frame_start = 1'b1;
          pixr(xx, oy + r * 8);
        end
      end
    end

    // Shadowing: mid-frame writes wait for frame_start; coincident write wins.
    fill_mem(2'b01);
    do_reset();
    wreg(3'd0, 32'd100); wreg(3'd1, 32'd50); wreg(3'd2, 32'd1);
    fs();
    wreg(3'd0, 32'd300);
    probe("old_x0_kept", 100, 50, 12'h111, 12'hFFF);
    probe("new_x0_pending", 300, 50, 12'h222, 12'h222);
    scan(96, 135, 50, 50);
    fs();
    probe("new_x0_active", 300, 50, 12'h333, 12'hFFF);
    probe("old_x0_gone", 100, 50, 12'h444, 12'h444);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'd500; frame_start = 1'b1;
    pix(300, 50, 12'h555);
    idle(); idle();
    chk("fs_pixel_uses_old", so_rgb, 12'hFFF);
    probe("same_cycle_write", 500, 50, 12'h666, 12'hFFF);
    probe("same_cycle_old_gone", 300, 50, 12'h777, 12'h777);

    // Blink: counter advances per frame, upper half of the period hides the cursor.
    do_reset();
    wreg(3'd0, 32'd300); wreg(3'd1, 32'd200); wreg(3'd2, 32'd3);
    for (int f = 0; f <= 64; f++) begin
      fs();
      probe($sformatf("blink_f%0d", f), 300, 200, 12'h0AB,
            (((f + 1) % 64) < 32) ? 12'hFFF : 12'h0AB);
    end

    // Right-edge origin: no wrap into low columns; partial cursor on a 640-wide line.
    wreg(3'd2, 32'd1); wreg(3'd0, 32'd2040); wreg(3'd1, 32'd0);
    fs();
    scan(0, 10, 0, 0);
    probe("x0_2040_x5", 5, 0, 12'h0C3, 12'h0C3);
    probe("x0_2040_x2047", 2047, 0, 12'h0C4, 12'hFFF);
    wreg(3'd0, 32'd630);
    fs();
    scan(600, 639, 0, 1);
    scan(0, 10, 1, 1);
    probe("x0_630_x630", 630, 0, 12'h0D1, 12'hFFF);
    probe("x0_630_x639", 639, 0, 12'h0D2, 12'hFFF);
    probe("x0_630_x629", 629, 0, 12'h0D3, 12'h0D3);
    probe("x0_630_left_edge", 0, 1, 12'h0D4, 12'h0D4);

    // Reset in the middle of an active overlay.
    wreg(3'd0, 32'd100); wreg(3'd1, 32'd50);
    fs();
    probe("overlay_before_rst", 110, 60, 12'h0E1, 12'hFFF);
    pixr(111, 60);
    pixr(112, 60);
    reset = 1'b1;
    pixr(113, 60);
    chk("rst_mid_so_rgb", so_rgb, 12'h000);
    reset = 1'b0;
    pix(110, 60, 12'h0F0);
    chk("post_rst_c1", so_rgb, 12'h000);
    pix(111, 60, 12'h0F0);
    chk("post_rst_c2", so_rgb, 12'h000);
    pix(112, 60, 12'h0F0);
    chk("post_rst_passthru", so_rgb, 12'h0F0);
    idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cursor_src.md
# cursor_src

Video-path stage directly downstream of the 32x32, 2-bit cursor bitmap RAM. It takes the current pixel coordinate from the frame counter and drives the RAM read address. It consumes the RAM's registered read data, maps the 2-bit code through a 3-entry palette and overlays the cursor onto the incoming RGB stream. Cursor position and enable are double-buffered and update only at frame start, so the cursor never tears.

## Interface
Parameters:
- CD, 12, RGB colour depth (bits)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- x  in  11  current pixel column from frame counter
- y  in  11  current pixel row from frame counter
- frame_start  in  1  one-cycle pulse at first pixel of a frame
- si_rgb  in  CD  upstream pixel colour, aligned with x/y
- wr_en  in  1  register write strobe
- wr_addr  in  3  register select
- wr_data  in  32  register write data
- ram_addr  out  10  cursor RAM read address {row[4:0], col[4:0]}
- ram_data  in  2  cursor RAM read data; 1-cycle registered latency from ram_addr
- so_rgb  out  CD  output pixel colour

## Operation
- Register map. Writes take effect on the clock edge where wr_en=1; there is no readback.
  - 0: x0 pending, wr_data[10:0]
  - 1: y0 pending, wr_data[10:0]
  - 2: ctrl pending; bit0 enable, bit1 blink
  - 3: palette1, wr_data[CD-1:0]
  - 4: palette2
  - 5: palette3
  - 6–7: ignored
- Shadowing:
  - x0/y0/ctrl writes land in pending registers.
  - On frame_start, pending copies into the active registers.
  - If a write and frame_start occur in the same cycle, active receives the newly written value.
  - Palette registers are not shadowed; they act immediately.
- Blink counter:
  - 6-bit, increments on each frame_start and wraps 63→0.
  - visible = active enable AND (NOT active blink OR counter[5]==0), i.e. 32 frames on, 32 off.
- Region test, in 12-bit arithmetic with zero-extended operands:
  - xr = x − x0, yr = y − y0.
  - Hit when xr[11:5]==0 and yr[11:5]==0.
  - x < x0 therefore never hits, and there is no wrap near 2047.
- Stage 1 (registered):
  - ram_addr ← {yr[4:0], xr[4:0]}
  - hit1 ← hit AND visible
  - rgb1 ← si_rgb
- Stage 2 (registered): hit2 ← hit1, rgb2 ← rgb1. ram_data is valid during this stage.
- Stage 3 (registered): so_rgb ←
  - rgb2 when hit2=0 or ram_data=00 (transparent)
  - palette1 / palette2 / palette3 for ram_data = 01 / 10 / 11
- No stall or back-pressure. The pipeline advances every clock.

## Timing
- Latency: x/y/si_rgb sampled at edge k → ram_addr valid after edge k → ram_data after k+1 → so_rgb after k+2. That is 3 clock edges; the integrator delays hsync/vsync by 3.
- Visibility is sampled at stage 1. A frame_start at edge k affects pixels sampled at edge k+1 onward; the pixel presented with frame_start uses the old active values.
- Reset values:
  - so_rgb=0, ram_addr=0, hit1=hit2=0, rgb1=rgb2=0
  - x0/y0 pending and active = 0, enable=blink=0 (cursor hidden), blink counter=0
  - palette1=all ones, palette2=0, palette3={CD/3 ones, rest 0} (red for CD=12)
- Reset mid-frame: all pipeline stages clear. so_rgb is 0 for the cycle after reset, then passes si_rgb until software re-enables the cursor.
- Boundaries:
  - x=x0+31 hits, x0+32 does not.
  - x0=2040, x=5 does not hit.
  - Cursor partly off-screen: only the visible part is drawn; no wrap to the left edge.

## Test plan
- Enable at x0=100, y0=50, RAM all 01, frame_start pulsed → so_rgb=palette1 for x=100..131, y=50..81 exactly. Elsewhere so_rgb equals si_rgb delayed 3 cycles.
- RAM pattern with code 00 at (col 3, row 0), 11 at (col 4, row 0) → pixel (103,50) passes si_rgb; (104,50) outputs palette3. ram_addr at the (104,50) sample equals 10'd4.
- Write x0=300 mid-frame without frame_start → cursor stays at 100. After frame_start, it draws at 300. Write and frame_start in the same cycle → new value used.
- Blink enabled, 64 frame_start pulses → cursor visible frames 0–31, hidden 32–63, visible again at frame 64.
- x0=2040, y0=0, scan x=0..10 → no hit. x0=630 on a 640-wide scan → columns 630–639 drawn only.
- Assert reset during active cursor overlay → so_rgb=0 next cycle. After release with si_rgb=12'h0F0, so_rgb=12'h0F0 three cycles later and the cursor is hidden.
